// File: rtl/register_file.sv
// ============================================================================
// Module   : register_file
// Brief    : 2-read / 1-write register file with registered read ports and an
//            output-valid strobe. Optional macro REGISTER_FILE_BYPASS_EN
//            selects write-first forwarding; read-first when undefined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] rA_select,
    input  logic [ADDR_WIDTH-1:0] rB_select,
    input  logic [ADDR_WIDTH-1:0] rD_select,
    input  logic [DATA_WIDTH-1:0] rD_in,
    input  logic                  rD_write,
    output logic [DATA_WIDTH-1:0] rA_out,
    output logic [DATA_WIDTH-1:0] rB_out,
    output logic                  out_valid
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic                  w_write;
    logic [DATA_WIDTH-1:0] w_rA_data;
    logic [DATA_WIDTH-1:0] w_rB_data;

    assign w_write = enable && rD_write;

`ifdef REGISTER_FILE_BYPASS_EN
    // Write-first: a same-edge write to the selected address is forwarded.
    assign w_rA_data = (w_write && (rD_select == rA_select)) ? rD_in : r_regs[rA_select];
    assign w_rB_data = (w_write && (rD_select == rB_select)) ? rD_in : r_regs[rB_select];
`else
    assign w_rA_data = r_regs[rA_select];
    assign w_rB_data = r_regs[rB_select];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[rD_select] <= rD_in;
        end
    end

    // Read data holds across disabled edges; only the strobe drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rA_out    <= '0;
            rB_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= enable;
            if (enable) begin
                rA_out <= w_rA_data;
                rB_out <= w_rB_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module   : tb_register_file
// Brief    : Self-checking bench for register_file (32-bit x 16 configuration)
//            against a behavioural array model; honours REGISTER_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NREG = 2 ** AW;
`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] rA_select;
    logic [AW-1:0] rB_select;
    logic [AW-1:0] rD_select;
    logic [DW-1:0] rD_in;
    logic          rD_write;
    logic [DW-1:0] rA_out;
    logic [DW-1:0] rB_out;
    logic          out_valid;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rA_select (rA_select),
        .rB_select (rB_select),
        .rD_select (rD_select),
        .rD_in     (rD_in),
        .rD_write  (rD_write),
        .rA_out    (rA_out),
        .rB_out    (rB_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [NREG];
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic          exp_v;

    // Reference: registered reads of the file as it stands before this edge,
    // except a same-address write is seen immediately when forwarding is on.
    task automatic do_edge(input bit en, input bit wr, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input logic [DW-1:0] din);
        enable = en; rD_write = wr; rA_select = a; rB_select = b;
        rD_select = d; rD_in = din;
        if (en) begin
            exp_a = (BYPASS && wr && d == a) ? din : model[a];
            exp_b = (BYPASS && wr && d == b) ? din : model[b];
            if (wr) model[d] = din;
        end
        exp_v = en;
        @(posedge clk); #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) model[i] = '0;
        exp_a = '0; exp_b = '0; exp_v = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable = 1'b0; rD_write = 1'b0;
        rA_select = '0; rB_select = '0; rD_select = '0; rD_in = '0;
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rA_out !== '0 || rB_out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rA=%h rB=%h v=%b expected 0 0 0", rA_out, rB_out, out_valid);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        do_edge(1, 1, 4'd0, 4'd0, 4'd2, 32'h0000_1234);
        do_edge(1, 0, 4'd2, 4'd2, 4'd0, 32'h0);
        checks++;
        if (rA_out !== 32'h1234 || rB_out !== 32'h1234 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL write_read: rA=%h rB=%h v=%b expected 1234 1234 1", rA_out, rB_out, out_valid);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        do_edge(1, 1, 4'd0, 4'd0, 4'd3, 32'h0000_00AA);
        do_edge(1, 1, 4'd3, 4'd0, 4'd3, 32'h0000_5555);
        want = BYPASS ? 32'h5555 : 32'h00AA;
        checks++;
        if (rA_out !== want || rB_out !== exp_b) begin
            errors++;
            $display("FAIL collision: rA=%h rB=%h expected %h %h", rA_out, rB_out, want, exp_b);
        end
        do_edge(1, 0, 4'd3, 4'd3, 4'd0, 32'h0);
        checks++;
        if (rA_out !== 32'h5555 || rB_out !== 32'h5555) begin
            errors++;
            $display("FAIL collision_next: rA=%h rB=%h expected 5555 5555", rA_out, rB_out);
        end
    endtask

    task automatic test_enable_gating();
        logic [DW-1:0] hold_a;
        logic [DW-1:0] hold_b;
        do_edge(1, 1, 4'd7, 4'd9, 4'd1, 32'h0000_0042);
        hold_a = rA_out; hold_b = rB_out;
        do_edge(0, 1, 4'd1, 4'd1, 4'd1, 32'h0000_FFFF);
        checks++;
        if (out_valid !== 1'b0 || rA_out !== hold_a || rB_out !== hold_b) begin
            errors++;
            $display("FAIL gating_hold: rA=%h rB=%h v=%b expected %h %h 0", rA_out, rB_out, out_valid, hold_a, hold_b);
        end
        do_edge(1, 0, 4'd1, 4'd1, 4'd0, 32'h0);
        checks++;
        if (rA_out !== 32'h42 || rB_out !== 32'h42 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gating_reg1: rA=%h rB=%h v=%b expected 42 42 1", rA_out, rB_out, out_valid);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < NREG; i++)
            do_edge(1, 1, AW'(i), AW'(i), AW'(i), DW'(i) * 32'h0101_0101);
        for (int i = 0; i < NREG; i++) begin
            do_edge(1, 0, AW'(i), AW'(NREG - 1 - i), 4'd0, 32'h0);
            checks++;
            if (rA_out !== DW'(i) * 32'h0101_0101 || rB_out !== DW'(NREG - 1 - i) * 32'h0101_0101) begin
                errors++;
                $display("FAIL sweep_%0d: rA=%h rB=%h expected %h %h", i, rA_out, rB_out,
                         DW'(i) * 32'h0101_0101, DW'(NREG - 1 - i) * 32'h0101_0101);
            end
        end
        do_edge(1, 0, 4'd15, 4'd15, 4'd0, 32'h0);
        checks++;
        if (rA_out !== 32'h0F0F_0F0F || rB_out !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL sweep_reg15: rA=%h rB=%h expected 0f0f0f0f", rA_out, rB_out);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            do_edge(1, (c % 2) == 0, AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
            checks++;
            if (out_valid !== 1'b1 || rA_out !== exp_a || rB_out !== exp_b) begin
                errors++;
                $display("FAIL back_to_back_%0d: rA=%h rB=%h v=%b expected %h %h 1", c, rA_out, rB_out, out_valid, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            do_edge($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
            checks++;
            if (out_valid !== exp_v || rA_out !== exp_a || rB_out !== exp_b) begin
                errors++;
                $display("FAIL random_%0d: rA=%h rB=%h v=%b expected %h %h %b", c, rA_out, rB_out, out_valid, exp_a, exp_b, exp_v);
            end
        end
    endtask

    task automatic test_reset_pulse();
        do_edge(1, 1, 4'd5, 4'd5, 4'd5, 32'h0000_BEEF);
        do_edge(1, 0, 4'd5, 4'd5, 4'd0, 32'h0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (rA_out !== '0 || rB_out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rA=%h rB=%h v=%b expected 0 0 0", rA_out, rB_out, out_valid);
        end
        enable = 1'b1; rD_write = 1'b1; rD_select = 4'd5; rD_in = 32'hFFFF_FFFF;
        rA_select = 4'd5; rB_select = 4'd5;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rA_out !== '0 || rB_out !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rA=%h rB=%h v=%b expected 0 0 0", rA_out, rB_out, out_valid);
        end
        #3 rst_n = 1'b1;
        do_edge(1, 0, 4'd5, 4'd5, 4'd0, 32'h0);
        checks++;
        if (rA_out !== '0 || rB_out !== '0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_reg5: rA=%h rB=%h v=%b expected 0 0 1", rA_out, rB_out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_enable_gating();
        test_sweep();
        test_back_to_back();
        test_random();
        test_reset_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, bit width of each register and of data ports.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 3, select width; depth = 2**ADDR_WIDTH registers.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port enable  input  1  qualifies reads and writes for the current edge.
REQ-006 SHALL provide port rA_select  input  ADDR_WIDTH  read port A address.
REQ-007 SHALL provide port rB_select  input  ADDR_WIDTH  read port B address.
REQ-008 SHALL provide port rD_select  input  ADDR_WIDTH  write port address.
REQ-009 SHALL provide port rD_in  input  DATA_WIDTH  write data.
REQ-010 SHALL provide port rD_write  input  1  write request, effective only with enable=1.
REQ-011 SHALL provide port rA_out  output  DATA_WIDTH  registered read data, port A.
REQ-012 SHALL provide port rB_out  output  DATA_WIDTH  registered read data, port B.
REQ-013 SHALL provide port out_valid  output  1  high for one cycle after each enabled edge; qualifies rA_out/rB_out.

Function
REQ-014 On rising clk with enable=1: rA_out <= reg[rA_select], rB_out <= reg[rB_select]; read latency exactly one cycle.
REQ-015 On rising clk with enable=1 and rD_write=1: reg[rD_select] <= rD_in; new value visible to a read sampled on the next enabled edge.
REQ-016 On rising clk with enable=0: no register written, rA_out/rB_out hold previous values, out_valid <= 0.
REQ-017 out_valid <= enable on every rising edge; back-to-back enabled edges keep out_valid high continuously.
REQ-018 Both read ports SHALL be independent; rA_select = rB_select returns identical data on both ports.
REQ-019 Every address 0..2**ADDR_WIDTH-1 SHALL be a real, writable register; no out-of-range case exists.
REQ-020 Same-edge write and read of the same address: read data per REQ-027/REQ-028.
REQ-021 rD_write=1 with enable=0 SHALL be ignored entirely (no write, no side effect).

Reset
REQ-022 rst_n=0 SHALL immediately, without clk, clear all registers to 0.
REQ-023 rst_n=0 SHALL immediately drive rA_out=0, rB_out=0, out_valid=0.
REQ-024 While rst_n=0, clk edges SHALL have no effect, including enable/rD_write.
REQ-025 Reset asserted mid-operation SHALL discard any write on that edge; no partial state survives.
REQ-026 First rising clk after rst_n rises SHALL behave as a normal edge per REQ-014..REQ-017.

Configuration
REQ-027 With macro REGISTER_FILE_BYPASS_EN defined: an enabled read whose select equals rD_select with rD_write=1 on the same edge SHALL return rD_in (write-first forwarding), per port independently.
REQ-028 Without REGISTER_FILE_BYPASS_EN: same case SHALL return the pre-write register contents (read-first); written value appears on the next enabled read.

Verification
REQ-029 Reset: pulse rst_n low between clk edges after writing 0xBEEF to reg 5 -> rA_out=rB_out=0, out_valid=0 at once; read reg 5 after release -> 0x0000.
REQ-030 Write/read: enable=1, write 0x1234 to reg 2, next edge read rA=2, rB=2 -> one cycle later rA_out=rB_out=0x1234, out_valid=1.
REQ-031 Collision: reg 3=0x00AA, same edge write 0x5555 to reg 3 and read rA=3 -> rA_out=0x5555 with REGISTER_FILE_BYPASS_EN, 0x00AA without; next read 0x5555 in both builds.
REQ-032 Enable gating: enable=0, rD_write=1, rD_select=1, rD_in=0xFFFF -> reg 1 unchanged, outputs hold, out_valid=0.
REQ-033 Full sweep: DATA_WIDTH=32, ADDR_WIDTH=4, write index*0x01010101 to all 16 regs, read back on both ports -> each matches, including reg 15 = 0x0F0F0F0F.
REQ-034 Back-to-back: enable high 8 consecutive cycles alternating writes and reads -> out_valid high for 8 consecutive cycles, data correct each cycle.
